bit_stream_source: RTL and testbench

Parametrised serial bit-pattern source for the bit-reversal datapath. Holds a programmable WIDTH-bit word and streams it one bit per transfer as ASCII '0'/'1' characters, with the selected bit index, on a valid/ready interface. Bit order is selectable per run (LSB-first or MSB-first), and the block supports single-shot and continuous (wrap) modes. It sits ahead of the reversal core as stimulus/feed source.

---
 rtl/bit_stream_source_pkg.sv | 13 +
 rtl/bit_stream_source_if.sv | 14 +
 rtl/bit_stream_source.sv | 86 ++++++++
 tb/tb_bit_stream_source.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bit_stream_source_pkg.sv
// Shared definitions for the bit-reversal datapath: ASCII codes, run states
// and the position-to-bit-index mapping used by source, core and sink.
package bitrev_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  // pos counts transfers within a word; msb selects which end it counts from
  function automatic int bit_sel_idx(input int pos, input logic msb, input int width);
    return msb ? (width - 1 - pos) : pos;
  endfunction
endpackage

// File: rtl/bit_stream_source_if.sv
// Valid/ready character stream carrying one bit of the word per transfer.
interface bit_stream_source_if #(parameter int WIDTH = 8);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_bit;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (output out_valid, out_char, out_bit, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_char, out_bit, out_idx, out_last, output out_ready);
endinterface

// File: rtl/bit_stream_source.sv
// Streams a held WIDTH-bit word one ASCII '0'/'1' per transfer, LSB- or
// MSB-first, single-shot or wrapping until stopped.
module bit_stream_source
  import bitrev_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             start,
  input  logic             msb_first,
  input  logic             continuous,
  input  logic             stop,
  bit_stream_source_if.master sif,
  output logic             busy,
  output logic             done
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic [IDX_W-1:0] pos;
  logic [IDX_W-1:0] idx;
  logic             msb_q;
  logic             cont_q;
  logic             stop_pending;
  logic             xfer;
  logic             at_last;

  // Presented bit is a pure function of registers, so it holds through stalls
  assign idx     = IDX_W'(bit_sel_idx(int'(pos), msb_q, WIDTH));
  assign at_last = (pos == LAST_POS);
  assign xfer    = sif.out_valid & sif.out_ready;

  assign sif.out_valid = (state == STREAM);
  assign sif.out_bit   = word_q[idx];
  assign sif.out_char  = word_q[idx] ? ASCII_ONE : ASCII_ZERO;
  assign sif.out_idx   = idx;
  assign sif.out_last  = at_last;
  assign busy          = (state == STREAM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      word_q       <= '0;
      pos          <= '0;
      msb_q        <= 1'b0;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) word_q <= load_word;
          if (start) begin
            msb_q        <= msb_first;
            cont_q       <= continuous;
            pos          <= '0;
            stop_pending <= 1'b0;
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (stop) stop_pending <= 1'b1;
          if (xfer) begin
            if (!at_last) begin
              pos <= pos + 1'b1;
            end else if (cont_q && !(stop_pending || stop)) begin
              pos <= '0;
            end else begin
              pos          <= '0;
              stop_pending <= 1'b0;
              done         <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_stream_source.sv
// Directed bench for bit_stream_source (WIDTH=8): table of single-shot runs
// plus hand-written continuous/stop and async-reset sequences.
module tb_bit_stream_source;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_word = '0;
  logic             start = 1'b0;
  logic             msb_first = 1'b0;
  logic             continuous = 1'b0;
  logic             stop = 1'b0;
  logic             busy;
  logic             done;

  bit_stream_source_if #(.WIDTH(WIDTH)) sif ();

  bit_stream_source #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_word  (load_word),
    .start      (start),
    .msb_first  (msb_first),
    .continuous (continuous),
    .stop       (stop),
    .sif        (sif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // exp_bits[k] is the bit value expected on transfer k, in run order
  typedef struct {
    logic [7:0] word;
    logic       do_load;
    logic       msb;
    logic [3:0] rdy;
    logic [7:0] exp_bits;
    logic       junk;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input int t, input logic msb, input logic b);
    logic [2:0] e_idx;
    e_idx = msb ? 3'(7 - t) : 3'(t);
    chk("valid", 32'(sif.out_valid), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    chk("idx", 32'(sif.out_idx), 32'(e_idx));
    chk("bit", 32'(sif.out_bit), 32'(b));
    chk("char", 32'(sif.out_char), b ? 32'h31 : 32'h30);
    chk("last", 32'(sif.out_last), 32'(t == 7));
  endtask

  task automatic chk_end();
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_end", 32'(sif.out_valid), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  task automatic run(input vec_t v);
    int t;
    int c;
    @(negedge clk);
    load = v.do_load; load_word = v.word; start = 1'b1;
    msb_first = v.msb; continuous = 1'b0; sif.out_ready = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b0; msb_first = ~v.msb; continuous = 1'b1;
    t = 0; c = 0;
    while (t < 8 && c < 64) begin
      sif.out_ready = v.rdy[c % 4];
      chk_beat(t, v.msb, v.exp_bits[t]);
      if (v.junk && t == 2) begin
        load = 1'b1; load_word = 8'hFF; start = 1'b1;
      end else begin
        load = 1'b0; start = 1'b0;
      end
      if (sif.out_ready) t++;
      c++;
      @(negedge clk);
    end
    load = 1'b0; start = 1'b0; sif.out_ready = 1'b0; continuous = 1'b0;
    if (t < 8) chk("run_timeout", 32'(t), 32'd8);
    chk_end();
  endtask

  initial begin
    int t;
    int c;
    vecs[0] = '{8'hF0, 1'b1, 1'b0, 4'b1111, 8'hF0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 4'b1111, 8'h0F, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 4'b1001, 8'hA5, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 4'b1010, 8'h80, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 4'b1111, 8'h3C, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 4'b1111, 8'h3C, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 4'b1111, 8'h3C, 1'b0};
    sif.out_ready = 1'b0;

    #12;
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_char", 32'(sif.out_char), 32'h30);
    chk("rst_idx", 32'(sif.out_idx), 32'd0);
    chk("rst_last", 32'(sif.out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // stop in IDLE must not leak into the next run
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // continuous 8'h01, stop on transfer 11 -> two full words, no bubble
    @(negedge clk);
    load = 1'b1; load_word = 8'h01; start = 1'b1; msb_first = 1'b0; continuous = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0; continuous = 1'b0;
    sif.out_ready = 1'b1;
    t = 0; c = 0;
    while (t < 16 && c < 64) begin
      chk_beat(t % 8, 1'b0, (t % 8) == 0);
      stop = (t == 11);
      t++; c++;
      @(negedge clk);
    end
    stop = 1'b0; sif.out_ready = 1'b0;
    chk_end();

    // async reset mid-run, then a run of the cleared word
    @(negedge clk);
    load = 1'b1; load_word = 8'hA5; start = 1'b1; msb_first = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b0; sif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_idx", 32'(sif.out_idx), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(sif.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_char", 32'(sif.out_char), 32'h30);
    sif.out_ready = 1'b0;
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    reset = 1'b1;
    run('{8'h00, 1'b0, 1'b0, 4'b1111, 8'h00, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
